// File: rtl/mc_port_arbiter.sv
// Round-robin arbiter sharing one memory-controller port among NUM_CORES cores.
// Requests are tagged with the core ID in rtnctl so responses can be steered back.
module mc_port_arbiter #(
  parameter int unsigned NUM_CORES       = 8,
  parameter int unsigned CID_WID         = 3,
  parameter int unsigned MC_RTNCTL_WIDTH = 32,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned TAG_WID        = MC_RTNCTL_WIDTH - CID_WID
) (
  input  logic                         clk,
  input  logic                         reset,
  // Core request side
  input  logic [NUM_CORES-1:0]         core_rq_vld,
  input  logic [3*NUM_CORES-1:0]       core_rq_cmd,
  input  logic [4*NUM_CORES-1:0]       core_rq_scmd,
  input  logic [48*NUM_CORES-1:0]      core_rq_vadr,
  input  logic [2*NUM_CORES-1:0]       core_rq_size,
  input  logic [64*NUM_CORES-1:0]      core_rq_data,
  input  logic [TAG_WID*NUM_CORES-1:0] core_rq_tag,
  output logic [NUM_CORES-1:0]         core_rq_gnt,
  // Core response side
  output logic [NUM_CORES-1:0]         core_rs_vld,
  output logic [2:0]                   core_rs_cmd,
  output logic [3:0]                   core_rs_scmd,
  output logic [TAG_WID-1:0]           core_rs_tag,
  output logic [63:0]                  core_rs_data,
  // Memory-controller request
  output logic                         mc_rq_vld,
  output logic [2:0]                   mc_rq_cmd,
  output logic [3:0]                   mc_rq_scmd,
  output logic [47:0]                  mc_rq_vadr,
  output logic [1:0]                   mc_rq_size,
  output logic [MC_RTNCTL_WIDTH-1:0]   mc_rq_rtnctl,
  output logic [63:0]                  mc_rq_data,
  output logic                         mc_rq_flush,
  input  logic                         mc_rq_stall,
  // Memory-controller response
  input  logic                         mc_rs_vld,
  input  logic [2:0]                   mc_rs_cmd,
  input  logic [3:0]                   mc_rs_scmd,
  input  logic [MC_RTNCTL_WIDTH-1:0]   mc_rs_rtnctl,
  input  logic [63:0]                  mc_rs_data,
  output logic                         mc_rs_stall,
  // Statistics and errors
  output logic [63:0]                  total_gnts,
  output logic [63:0]                  total_q_conf,
  output logic                         err_bad_tag
);

  localparam int unsigned IdSpace = 1 << CID_WID;
  localparam logic [3:0]  MaxOut  = 4'(MAX_OUTSTANDING);

  // Arbitration
  logic [NUM_CORES-1:0] eligible;
  logic [CID_WID:0]     elig_cnt;
  logic                 can_issue;
  logic                 found;
  logic                 gnt_any;
  logic [CID_WID-1:0]   gnt_idx;
  logic [CID_WID-1:0]   cand;

  // Selected request fields
  logic [2:0]           sel_cmd;
  logic [3:0]           sel_scmd;
  logic [47:0]          sel_vadr;
  logic [1:0]           sel_size;
  logic [63:0]          sel_data;
  logic [TAG_WID-1:0]   sel_tag;

  // Response decode
  logic [IdSpace-1:0]   id_ok;
  logic [CID_WID-1:0]   rs_id;
  logic                 rs_take;

  // State
  logic [CID_WID-1:0]                rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0][3:0]         outst_q, outst_d;
  logic [NUM_CORES-1:0]              outst_inc, outst_dec;
  logic                              orq_vld_q, orq_vld_d;
  logic [2:0]                        orq_cmd_q, orq_cmd_d;
  logic [3:0]                        orq_scmd_q, orq_scmd_d;
  logic [47:0]                       orq_vadr_q, orq_vadr_d;
  logic [1:0]                        orq_size_q, orq_size_d;
  logic [MC_RTNCTL_WIDTH-1:0]        orq_rtnctl_q, orq_rtnctl_d;
  logic [63:0]                       orq_data_q, orq_data_d;
  logic [NUM_CORES-1:0]              rs_vld_q, rs_vld_d;
  logic [2:0]                        rs_cmd_q, rs_cmd_d;
  logic [3:0]                        rs_scmd_q, rs_scmd_d;
  logic [TAG_WID-1:0]                rs_tag_q, rs_tag_d;
  logic [63:0]                       rs_data_q, rs_data_d;
  logic [63:0]                       gnts_q, gnts_d;
  logic [63:0]                       conf_q, conf_d;
  logic                              err_q, err_d;

  always_comb begin
    eligible = '0;
    elig_cnt = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      eligible[i] = core_rq_vld[i] && (outst_q[i] < MaxOut);
      elig_cnt    = elig_cnt + (CID_WID+1)'(eligible[i]);
    end
  end

  // A stalled, occupied output register blocks all grants; reset also masks them.
  assign can_issue = !reset && (!orq_vld_q || !mc_rq_stall);

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned off = 0; off < NUM_CORES; off++) begin
      cand = rr_ptr_q + CID_WID'(off);
      if (!found && eligible[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_any     = found && can_issue;
    core_rq_gnt = '0;
    if (gnt_any) core_rq_gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_cmd  = '0;
    sel_scmd = '0;
    sel_vadr = '0;
    sel_size = '0;
    sel_data = '0;
    sel_tag  = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (gnt_idx == CID_WID'(i)) begin
        sel_cmd  = core_rq_cmd[i*3 +: 3];
        sel_scmd = core_rq_scmd[i*4 +: 4];
        sel_vadr = core_rq_vadr[i*48 +: 48];
        sel_size = core_rq_size[i*2 +: 2];
        sel_data = core_rq_data[i*64 +: 64];
        sel_tag  = core_rq_tag[i*TAG_WID +: TAG_WID];
      end
    end
  end

  // IDs beyond NUM_CORES only exist when NUM_CORES is below the ID space.
  always_comb begin
    id_ok = '0;
    for (int unsigned i = 0; i < IdSpace; i++) id_ok[i] = (i < NUM_CORES);
  end

  assign rs_id   = mc_rs_rtnctl[MC_RTNCTL_WIDTH-1 -: CID_WID];
  assign rs_take = mc_rs_vld && id_ok[rs_id];

  always_comb begin
    outst_inc = '0;
    outst_dec = '0;
    outst_d   = outst_q;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      outst_inc[i] = gnt_any && (gnt_idx == CID_WID'(i));
      outst_dec[i] = rs_take && (rs_id == CID_WID'(i));
      if (outst_inc[i] && !outst_dec[i]) begin
        outst_d[i] = outst_q[i] + 4'd1;
      end else if (outst_dec[i] && !outst_inc[i] && (outst_q[i] != 4'd0)) begin
        outst_d[i] = outst_q[i] - 4'd1;
      end
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    orq_vld_d    = orq_vld_q;
    orq_cmd_d    = orq_cmd_q;
    orq_scmd_d   = orq_scmd_q;
    orq_vadr_d   = orq_vadr_q;
    orq_size_d   = orq_size_q;
    orq_rtnctl_d = orq_rtnctl_q;
    orq_data_d   = orq_data_q;
    gnts_d       = gnts_q;
    conf_d       = conf_q;
    if (gnt_any) begin
      rr_ptr_d     = gnt_idx + CID_WID'(1);
      orq_vld_d    = 1'b1;
      orq_cmd_d    = sel_cmd;
      orq_scmd_d   = sel_scmd;
      orq_vadr_d   = sel_vadr;
      orq_size_d   = sel_size;
      orq_rtnctl_d = {gnt_idx, sel_tag};
      orq_data_d   = sel_data;
      gnts_d       = gnts_q + 64'd1;
      if (elig_cnt >= (CID_WID+1)'(2)) conf_d = conf_q + 64'd1;
    end else if (orq_vld_q && !mc_rq_stall) begin
      orq_vld_d = 1'b0;
    end
  end

  always_comb begin
    rs_vld_d  = '0;
    rs_cmd_d  = rs_cmd_q;
    rs_scmd_d = rs_scmd_q;
    rs_tag_d  = rs_tag_q;
    rs_data_d = rs_data_q;
    if (rs_take) begin
      rs_vld_d[rs_id] = 1'b1;
      rs_cmd_d        = mc_rs_cmd;
      rs_scmd_d       = mc_rs_scmd;
      rs_tag_d        = mc_rs_rtnctl[TAG_WID-1:0];
      rs_data_d       = mc_rs_data;
    end
    err_d = err_q || (mc_rs_vld && !id_ok[rs_id]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      outst_q      <= '0;
      orq_vld_q    <= 1'b0;
      orq_cmd_q    <= '0;
      orq_scmd_q   <= '0;
      orq_vadr_q   <= '0;
      orq_size_q   <= '0;
      orq_rtnctl_q <= '0;
      orq_data_q   <= '0;
      rs_vld_q     <= '0;
      rs_cmd_q     <= '0;
      rs_scmd_q    <= '0;
      rs_tag_q     <= '0;
      rs_data_q    <= '0;
      gnts_q       <= '0;
      conf_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      outst_q      <= outst_d;
      orq_vld_q    <= orq_vld_d;
      orq_cmd_q    <= orq_cmd_d;
      orq_scmd_q   <= orq_scmd_d;
      orq_vadr_q   <= orq_vadr_d;
      orq_size_q   <= orq_size_d;
      orq_rtnctl_q <= orq_rtnctl_d;
      orq_data_q   <= orq_data_d;
      rs_vld_q     <= rs_vld_d;
      rs_cmd_q     <= rs_cmd_d;
      rs_scmd_q    <= rs_scmd_d;
      rs_tag_q     <= rs_tag_d;
      rs_data_q    <= rs_data_d;
      gnts_q       <= gnts_d;
      conf_q       <= conf_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    mc_rq_vld    = orq_vld_q;
    mc_rq_cmd    = orq_cmd_q;
    mc_rq_scmd   = orq_scmd_q;
    mc_rq_vadr   = orq_vadr_q;
    mc_rq_size   = orq_size_q;
    mc_rq_rtnctl = orq_rtnctl_q;
    mc_rq_data   = orq_data_q;
    mc_rq_flush  = 1'b0;
    mc_rs_stall  = 1'b0;
    core_rs_vld  = rs_vld_q;
    core_rs_cmd  = rs_cmd_q;
    core_rs_scmd = rs_scmd_q;
    core_rs_tag  = rs_tag_q;
    core_rs_data = rs_data_q;
    total_gnts   = gnts_q;
    total_q_conf = conf_q;
    err_bad_tag  = err_q;
  end

endmodule

// File: tb/tb_mc_port_arbiter.sv
// Directed bench for mc_port_arbiter with the default 8-core, 29-bit-tag configuration.
module tb_mc_port_arbiter;

  localparam int N  = 8;
  localparam int TW = 29;

  logic clk;
  logic reset;
  logic [N-1:0]      core_rq_vld;
  logic [3*N-1:0]    core_rq_cmd;
  logic [4*N-1:0]    core_rq_scmd;
  logic [48*N-1:0]   core_rq_vadr;
  logic [2*N-1:0]    core_rq_size;
  logic [64*N-1:0]   core_rq_data;
  logic [TW*N-1:0]   core_rq_tag;
  logic [N-1:0]      core_rq_gnt;
  logic [N-1:0]      core_rs_vld;
  logic [2:0]        core_rs_cmd;
  logic [3:0]        core_rs_scmd;
  logic [TW-1:0]     core_rs_tag;
  logic [63:0]       core_rs_data;
  logic              mc_rq_vld;
  logic [2:0]        mc_rq_cmd;
  logic [3:0]        mc_rq_scmd;
  logic [47:0]       mc_rq_vadr;
  logic [1:0]        mc_rq_size;
  logic [31:0]       mc_rq_rtnctl;
  logic [63:0]       mc_rq_data;
  logic              mc_rq_flush;
  logic              mc_rq_stall;
  logic              mc_rs_vld;
  logic [2:0]        mc_rs_cmd;
  logic [3:0]        mc_rs_scmd;
  logic [31:0]       mc_rs_rtnctl;
  logic [63:0]       mc_rs_data;
  logic              mc_rs_stall;
  logic [63:0]       total_gnts;
  logic [63:0]       total_q_conf;
  logic              err_bad_tag;

  logic [N-1:0]  vld_a;
  logic [TW-1:0] tag_a  [N];
  logic [47:0]   vadr_a [N];

  int checks = 0;
  int errors = 0;

  mc_port_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .core_rq_vld  (core_rq_vld),
    .core_rq_cmd  (core_rq_cmd),
    .core_rq_scmd (core_rq_scmd),
    .core_rq_vadr (core_rq_vadr),
    .core_rq_size (core_rq_size),
    .core_rq_data (core_rq_data),
    .core_rq_tag  (core_rq_tag),
    .core_rq_gnt  (core_rq_gnt),
    .core_rs_vld  (core_rs_vld),
    .core_rs_cmd  (core_rs_cmd),
    .core_rs_scmd (core_rs_scmd),
    .core_rs_tag  (core_rs_tag),
    .core_rs_data (core_rs_data),
    .mc_rq_vld    (mc_rq_vld),
    .mc_rq_cmd    (mc_rq_cmd),
    .mc_rq_scmd   (mc_rq_scmd),
    .mc_rq_vadr   (mc_rq_vadr),
    .mc_rq_size   (mc_rq_size),
    .mc_rq_rtnctl (mc_rq_rtnctl),
    .mc_rq_data   (mc_rq_data),
    .mc_rq_flush  (mc_rq_flush),
    .mc_rq_stall  (mc_rq_stall),
    .mc_rs_vld    (mc_rs_vld),
    .mc_rs_cmd    (mc_rs_cmd),
    .mc_rs_scmd   (mc_rs_scmd),
    .mc_rs_rtnctl (mc_rs_rtnctl),
    .mc_rs_data   (mc_rs_data),
    .mc_rs_stall  (mc_rs_stall),
    .total_gnts   (total_gnts),
    .total_q_conf (total_q_conf),
    .err_bad_tag  (err_bad_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every core issues a read (cmd 1, size 3) with data 0xD0+i.
  always_comb begin
    core_rq_vld = vld_a;
    for (int k = 0; k < N; k++) begin
      core_rq_cmd[k*3 +: 3]   = 3'd1;
      core_rq_scmd[k*4 +: 4]  = 4'd0;
      core_rq_size[k*2 +: 2]  = 2'd3;
      core_rq_data[k*64 +: 64] = 64'hD0 + 64'(k);
      core_rq_vadr[k*48 +: 48] = vadr_a[k];
      core_rq_tag[k*TW +: TW]  = tag_a[k];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic [2:0] i, input logic [TW-1:0] tag, input logic [47:0] va);
    vld_a[i]  = 1'b1;
    tag_a[i]  = tag;
    vadr_a[i] = va;
  endtask

  task automatic clear_inputs;
    vld_a        = '0;
    mc_rq_stall  = 1'b0;
    mc_rs_vld    = 1'b0;
    mc_rs_cmd    = '0;
    mc_rs_scmd   = '0;
    mc_rs_rtnctl = '0;
    mc_rs_data   = '0;
    for (int k = 0; k < N; k++) begin
      tag_a[k]  = '0;
      vadr_a[k] = '0;
    end
  endtask

  task automatic apply_reset;
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset = 1'b1;
    vld_a = 8'hFF;
    tick();
    tick();
    checks++; if (core_rq_gnt !== 8'h00) begin errors++;
      $display("FAIL rst_gnt: got %h want %h", core_rq_gnt, 8'h00); end
    checks++; if (mc_rq_vld !== 1'b0) begin errors++;
      $display("FAIL rst_mc_rq_vld: got %b want 0", mc_rq_vld); end
    checks++; if (mc_rq_rtnctl !== 32'h0) begin errors++;
      $display("FAIL rst_rtnctl: got %h want 0", mc_rq_rtnctl); end
    checks++; if (core_rs_vld !== 8'h00) begin errors++;
      $display("FAIL rst_rs_vld: got %h want 0", core_rs_vld); end
    checks++; if (total_gnts !== 64'd0 || total_q_conf !== 64'd0) begin errors++;
      $display("FAIL rst_counters: got %0d/%0d want 0/0", total_gnts, total_q_conf); end
    checks++; if (err_bad_tag !== 1'b0) begin errors++;
      $display("FAIL rst_err: got %b want 0", err_bad_tag); end
    checks++; if (mc_rq_flush !== 1'b0 || mc_rs_stall !== 1'b0) begin errors++;
      $display("FAIL rst_tieoffs: got %b%b want 00", mc_rq_flush, mc_rs_stall); end
    reset = 1'b0;
    vld_a = '0;
    tick();
  endtask

  task automatic test_single;
    apply_reset();
    set_core(3'd2, 29'h5, 48'h100);
    #1;
    checks++; if (core_rq_gnt !== 8'h04) begin errors++;
      $display("FAIL single_gnt: got %h want %h", core_rq_gnt, 8'h04); end
    tick();
    vld_a = '0;
    checks++; if (mc_rq_vld !== 1'b1 || mc_rq_rtnctl !== 32'h4000_0005) begin errors++;
      $display("FAIL single_rq: got vld %b rtnctl %h want 1 40000005", mc_rq_vld, mc_rq_rtnctl); end
    checks++; if (mc_rq_vadr !== 48'h100 || mc_rq_cmd !== 3'd1 || mc_rq_data !== 64'hD2) begin
      errors++;
      $display("FAIL single_fields: got %h %h %h want 100 1 d2", mc_rq_vadr, mc_rq_cmd, mc_rq_data);
    end
    tick();
    checks++; if (mc_rq_vld !== 1'b0) begin errors++;
      $display("FAIL single_rq_drain: got %b want 0", mc_rq_vld); end
    mc_rs_vld    = 1'b1;
    mc_rs_cmd    = 3'd2;
    mc_rs_rtnctl = 32'h4000_0005;
    mc_rs_data   = 64'hCAFE;
    tick();
    mc_rs_vld = 1'b0;
    checks++; if (core_rs_vld !== 8'h04 || core_rs_tag !== 29'h5) begin errors++;
      $display("FAIL single_rs: got %h tag %h want 04 tag 5", core_rs_vld, core_rs_tag); end
    checks++; if (core_rs_data !== 64'hCAFE || core_rs_cmd !== 3'd2) begin errors++;
      $display("FAIL single_rs_fields: got %h %h want cafe 2", core_rs_data, core_rs_cmd); end
    checks++; if (total_gnts !== 64'd1) begin errors++;
      $display("FAIL single_total: got %0d want 1", total_gnts); end
    tick();
    checks++; if (core_rs_vld !== 8'h00) begin errors++;
      $display("FAIL single_rs_pulse: got %h want 00", core_rs_vld); end
  endtask

  task automatic test_all_cores;
    apply_reset();
    for (int i = 0; i < N; i++) set_core(3'(i), 29'h10 + 29'(i), 48'h1000 + 48'(i * 16));
    for (int n = 0; n < 9; n++) begin
      #1;
      checks++; if (core_rq_gnt !== (8'd1 << (n % 8))) begin errors++;
        $display("FAIL rr_gnt[%0d]: got %h want %h", n, core_rq_gnt, 8'd1 << (n % 8)); end
      tick();
      checks++; if (mc_rq_rtnctl[31:29] !== 3'(n % 8)) begin errors++;
        $display("FAIL rr_rtnctl[%0d]: got %0d want %0d", n, mc_rq_rtnctl[31:29], n % 8); end
    end
    vld_a = '0;
    checks++; if (total_gnts !== 64'd9 || total_q_conf !== 64'd9) begin errors++;
      $display("FAIL rr_counters: got %0d/%0d want 9/9", total_gnts, total_q_conf); end
  endtask

  task automatic test_stall;
    apply_reset();
    set_core(3'd1, 29'h11, 48'h2000);
    set_core(3'd4, 29'h44, 48'h4000);
    #1;
    checks++; if (core_rq_gnt !== 8'h02) begin errors++;
      $display("FAIL stall_first_gnt: got %h want 02", core_rq_gnt); end
    tick();
    vld_a[1]    = 1'b0;
    mc_rq_stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (core_rq_gnt !== 8'h00) begin errors++;
        $display("FAIL stall_gnt[%0d]: got %h want 00", c, core_rq_gnt); end
      checks++;
      if (mc_rq_vld !== 1'b1 || mc_rq_rtnctl !== 32'h2000_0011 || mc_rq_vadr !== 48'h2000) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %b %h %h want 1 20000011 2000", c, mc_rq_vld,
                 mc_rq_rtnctl, mc_rq_vadr);
      end
      tick();
    end
    mc_rq_stall = 1'b0;
    #1;
    checks++; if (core_rq_gnt !== 8'h10) begin errors++;
      $display("FAIL stall_release_gnt: got %h want 10", core_rq_gnt); end
    tick();
    vld_a = '0;
    checks++; if (mc_rq_vld !== 1'b1 || mc_rq_rtnctl !== 32'h8000_0044) begin errors++;
      $display("FAIL stall_next_rq: got %b %h want 1 80000044", mc_rq_vld, mc_rq_rtnctl); end
    tick();
    checks++; if (mc_rq_vld !== 1'b0) begin errors++;
      $display("FAIL stall_drain: got %b want 0", mc_rq_vld); end
    checks++; if (total_gnts !== 64'd2 || total_q_conf !== 64'd1) begin errors++;
      $display("FAIL stall_counters: got %0d/%0d want 2/1", total_gnts, total_q_conf); end
  endtask

  task automatic test_max_outstanding;
    apply_reset();
    set_core(3'd0, 29'h7, 48'h0);
    for (int n = 0; n < 4; n++) begin
      #1;
      checks++; if (core_rq_gnt !== 8'h01) begin errors++;
        $display("FAIL maxout_gnt[%0d]: got %h want 01", n, core_rq_gnt); end
      tick();
    end
    for (int n = 0; n < 2; n++) begin
      checks++; if (core_rq_gnt !== 8'h00) begin errors++;
        $display("FAIL maxout_masked[%0d]: got %h want 00", n, core_rq_gnt); end
      tick();
    end
    checks++; if (total_gnts !== 64'd4) begin errors++;
      $display("FAIL maxout_total: got %0d want 4", total_gnts); end
    mc_rs_vld    = 1'b1;
    mc_rs_rtnctl = 32'h0000_0007;
    tick();
    mc_rs_vld = 1'b0;
    checks++; if (core_rs_vld !== 8'h01 || core_rq_gnt !== 8'h01) begin errors++;
      $display("FAIL maxout_restore: got rs %h gnt %h want 01 01", core_rs_vld, core_rq_gnt); end
    tick();
    checks++; if (core_rq_gnt !== 8'h00 || total_gnts !== 64'd5) begin errors++;
      $display("FAIL maxout_remask: got gnt %h total %0d want 00 5", core_rq_gnt, total_gnts); end
    vld_a = '0;
  endtask

  task automatic test_same_cycle;
    int g;
    apply_reset();
    set_core(3'd3, 29'h33, 48'h3000);
    tick();
    mc_rs_vld    = 1'b1;
    mc_rs_rtnctl = 32'h6000_0033;
    #1;
    checks++; if (core_rq_gnt !== 8'h08) begin errors++;
      $display("FAIL same_gnt: got %h want 08", core_rq_gnt); end
    tick();
    mc_rs_vld = 1'b0;
    checks++; if (core_rs_vld !== 8'h08) begin errors++;
      $display("FAIL same_rs: got %h want 08", core_rs_vld); end
    // One outstanding remains, so exactly three more grants fit.
    g = 0;
    for (int c = 0; c < 6; c++) begin
      if (core_rq_gnt[3] === 1'b1) g++;
      tick();
    end
    checks++; if (g !== 3) begin errors++;
      $display("FAIL same_outstanding: got %0d grants want 3", g); end
    vld_a = '0;
  endtask

  task automatic test_reset_mid;
    apply_reset();
    set_core(3'd5, 29'h55, 48'h5000);
    tick();
    tick();
    checks++; if (mc_rq_vld !== 1'b1 || mc_rq_rtnctl[31:29] !== 3'd5) begin errors++;
      $display("FAIL mid_pre: got %b %h want 1 id5", mc_rq_vld, mc_rq_rtnctl); end
    reset = 1'b1;
    set_core(3'd2, 29'h22, 48'h2200);
    #1;
    checks++; if (core_rq_gnt !== 8'h00) begin errors++;
      $display("FAIL mid_gnt_in_reset: got %h want 00", core_rq_gnt); end
    tick();
    checks++; if (mc_rq_vld !== 1'b0 || mc_rq_rtnctl !== 32'h0 || mc_rq_vadr !== 48'h0) begin
      errors++;
      $display("FAIL mid_orq: got %b %h %h want 0 0 0", mc_rq_vld, mc_rq_rtnctl, mc_rq_vadr);
    end
    checks++; if (total_gnts !== 64'd0 || total_q_conf !== 64'd0) begin errors++;
      $display("FAIL mid_counters: got %0d/%0d want 0/0", total_gnts, total_q_conf); end
    reset = 1'b0;
    #1;
    checks++; if (core_rq_gnt !== 8'h04) begin errors++;
      $display("FAIL mid_first_gnt: got %h want 04", core_rq_gnt); end
    tick();
    vld_a = '0;
    checks++; if (mc_rq_rtnctl !== 32'h4000_0022) begin errors++;
      $display("FAIL mid_first_rq: got %h want 40000022", mc_rq_rtnctl); end
  endtask

  task automatic test_back_to_back;
    int g;
    apply_reset();
    mc_rs_vld    = 1'b1;
    mc_rs_rtnctl = 32'h2000_00AA;
    mc_rs_data   = 64'd1;
    tick();
    mc_rs_rtnctl = 32'hC000_00BB;
    mc_rs_data   = 64'd2;
    checks++; if (core_rs_vld !== 8'h02 || core_rs_tag !== 29'hAA || core_rs_data !== 64'd1) begin
      errors++;
      $display("FAIL b2b_rs0: got %h %h %h want 02 aa 1", core_rs_vld, core_rs_tag, core_rs_data);
    end
    tick();
    mc_rs_vld = 1'b0;
    checks++; if (core_rs_vld !== 8'h40 || core_rs_tag !== 29'hBB || core_rs_data !== 64'd2) begin
      errors++;
      $display("FAIL b2b_rs1: got %h %h %h want 40 bb 2", core_rs_vld, core_rs_tag, core_rs_data);
    end
    tick();
    checks++; if (core_rs_vld !== 8'h00 || err_bad_tag !== 1'b0) begin errors++;
      $display("FAIL b2b_idle: got %h err %b want 00 0", core_rs_vld, err_bad_tag); end
    // Responses with nothing outstanding must saturate at zero.
    set_core(3'd1, 29'h1, 48'h10);
    g = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (core_rq_gnt[1] === 1'b1) g++;
      tick();
    end
    vld_a = '0;
    checks++; if (g !== 4) begin errors++;
      $display("FAIL b2b_saturate: got %0d grants want 4", g); end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_all_cores();
    test_stall();
    test_max_outstanding();
    test_same_cycle();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
